mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port LC-3 program SRAM between two requesters: port A (CPU datapath MAR/MDR
//  path) and port B (debug/program loader). Decodes the memory-mapped I/O word at IO_ADDR:
//  reads return the switches, writes load the hex display register.
//  Sits between slc3 core, debug loader, on-chip SRAM and the board SW/HEX pins.
// PARAMETERS
//  ADDR_W   16        address width
//  DATA_W   16        data width
//  SW_W     10        switch input width, zero-extended on I/O read
//  MEM_LAT  2         SRAM cycles per access (ce held this long), >= 1
//  IO_ADDR  16'hFFFF  memory-mapped I/O address
// PORTS
//  Clk        in   1        rising-edge clock
//  Reset_n    in   1        asynchronous, active-low reset
//  req_a      in   1        CPU request; level, hold until done_a
//  we_a       in   1        CPU write(1)/read(0)
//  addr_a     in   ADDR_W   CPU address
//  wdata_a    in   DATA_W   CPU write data
//  done_a     out  1        one-cycle completion pulse to CPU
//  rdata_a    out  DATA_W   read data, valid while done_a=1
//  req_b/we_b/addr_b/wdata_b/done_b/rdata_b   same set for loader port B
//  gnt_a      out  1        A owns the memory (ACCESS/DONE states)
//  gnt_b      out  1        B owns the memory
//  mem_ce     out  1        SRAM chip enable
//  mem_we     out  1        SRAM write enable (only with mem_ce)
//  mem_addr   out  ADDR_W   SRAM address
//  mem_wdata  out  DATA_W   SRAM write data
//  mem_rdata  in   DATA_W   SRAM read data, valid on last ce cycle
//  sw         in   SW_W     board switches
//  hex_out    out  DATA_W   hex display register
//  busy       out  1        state != IDLE
// BEHAVIOUR
//  - Reset (async, Reset_n=0): state IDLE; all outputs 0, hex_out=0; rr pointer=B, so A wins first tie.
//  - FSM IDLE -> ACCESS -> DONE -> IDLE; IO access goes IDLE -> DONE directly.
//  - IDLE: on edge with any req, pick winner; latch we/addr/wdata; set gnt_x.
//    Only one req: grant it. Both: grant the port not granted last; pointer updates on grant.
//  - Latched addr == IO_ADDR: next state DONE.
//    Read: rdata={0,sw} sampled at grant edge. Write: hex_out<=wdata at grant edge. SRAM untouched.
//  - Else ACCESS: cnt=MEM_LAT-1; mem_ce=1, mem_we=latched we, addr/wdata from latch. Decrement per edge.
//    Edge with cnt==0: capture mem_rdata (reads) and go DONE.
//  - DONE: done_x=1 and rdata_x valid for exactly one cycle; gnt_x held; next edge -> IDLE.
//  - Latency from sampling edge to done_x high: SRAM MEM_LAT+1 cycles, I/O 1 cycle.
//    Min SRAM request spacing: MEM_LAT+2 cycles.
//  - Requester must drop req in its done cycle; req still high in IDLE is a new request.
//  - Requester dropping req mid-ACCESS: access completes, done pulses, no retry.
//  - Inputs other than req_x are ignored after grant (latched copy used).
//  - rdata_x/done_x of the non-owner port stay 0.
//  - Writes with mem_we: SRAM write lasts all MEM_LAT ce cycles; rdata_x=0 on write done.
// STRUCTURE
//  - lc3_mem_pkg: typedef enum logic[1:0] {ARB_IDLE, ARB_ACCESS, ARB_DONE} arb_state_t;
//    IO_ADDR default constant.
//  - Sub-module rr_pick2: 2-way round-robin pick with last-grant pointer (comb pick + ff pointer).
//  - Top: FSM, latency counter ($clog2(MEM_LAT+1) bits), request latch, hex register.
// TESTING  (MEM_LAT=2 unless stated)
//  1. Read: A reads 16'h0010, SRAM model returns 16'h1234 -> mem_ce high 2 cycles, mem_we=0;
//     done_a 3 cycles after sampling edge; rdata_a=16'h1234; gnt_b never set.
//  2. Tie: req_a, req_b both high from reset -> order A, B, A over three rounds;
//     no overlapping gnt; done_b never with done_a.
//  3. I/O read: B reads 16'hFFFF with sw=10'h0A6 -> rdata_b=16'h00A6 one cycle after sampling;
//     mem_ce stays 0.
//  4. I/O write: A writes 16'hBEEF to 16'hFFFF -> hex_out=16'hBEEF;
//     then SRAM write 16'h0020 -> hex_out unchanged, mem_we=1 for 2 cycles.
//  5. Mid-op: Reset_n=0 in ACCESS -> mem_ce, gnt, busy, hex_out 0 before next edge; IDLE after release.
//     req_a dropped mid-ACCESS -> one done_a pulse, no second access.
//  6. MEM_LAT=1 rerun of 1 and 2 -> done 2 cycles after sampling; back-to-back period 3 cycles.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory port arbiter.
//   arb_state_t     : arbiter FSM state encoding
//   IO_ADDR_DEFAULT : default memory-mapped I/O word (switches / hex display)
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_t;

    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every non-clock signal of mem_port_arbiter.
//   slave  : the arbiter side (takes requests, drives SRAM, switches in, hex out)
//   master : the environment side (CPU, loader, SRAM, board pins)
//
// Request handshake (both ports): the requester raises req_x with we_x/addr_x/
// wdata_x and holds req_x high until done_x pulses for exactly one cycle;
// rdata_x is valid only in that cycle. The requester must drop req_x in the
// done cycle, otherwise the arbiter sees a fresh request once back in IDLE.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int SW_W   = 10
);
    logic              req_a;
    logic              we_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wdata_a;
    logic              done_a;
    logic [DATA_W-1:0] rdata_a;

    logic              req_b;
    logic              we_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_b;
    logic              done_b;
    logic [DATA_W-1:0] rdata_b;

    logic              gnt_a;
    logic              gnt_b;

    logic              mem_ce;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [SW_W-1:0]   sw;
    logic [DATA_W-1:0] hex_out;
    logic              busy;

    modport slave (
        input  req_a, we_a, addr_a, wdata_a,
        output done_a, rdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        output done_b, rdata_b,
        output gnt_a, gnt_b,
        output mem_ce, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        input  sw,
        output hex_out, busy
    );

    modport master (
        output req_a, we_a, addr_a, wdata_a,
        input  done_a, rdata_a,
        output req_b, we_b, addr_b, wdata_b,
        input  done_b, rdata_b,
        input  gnt_a, gnt_b,
        input  mem_ce, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        output sw,
        input  hex_out, busy
    );
endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin picker.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_a/b    : current requests
//   grant_en   : high when the caller will act on the pick this cycle
//   pick_b     : 1 = port B wins, 0 = port A wins (meaningful when any req)
// The pointer remembers the last granted port; it resets to B so A wins the
// first tie after reset.
module rr_pick2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic grant_en,
    output logic pick_b
);
    logic last_b_q;
    logic last_b_d;

    always_comb begin
        pick_b   = (req_a && req_b) ? !last_b_q : req_b;
        last_b_d = last_b_q;
        if (grant_en && (req_a || req_b)) begin
            last_b_d = pick_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b_q <= 1'b1;
        end else begin
            last_b_q <= last_b_d;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port LC-3 program SRAM between the CPU (port A) and the
// debug loader (port B), and decodes the memory-mapped I/O word IO_ADDR:
// reads return the zero-extended switches, writes load the hex display.
//   Clk, Reset_n : clock, asynchronous active-low reset
//   bus          : requests, SRAM pins, switches, hex display, busy
//   state_dbg    : current FSM state
module mem_port_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int              ADDR_W  = 16,
    parameter int              DATA_W  = 16,
    parameter int              SW_W    = 10,
    parameter int              MEM_LAT = 2,
    parameter logic [ADDR_W-1:0] IO_ADDR = ADDR_W'(IO_ADDR_DEFAULT)
) (
    input  logic                Clk,
    input  logic                Reset_n,
    mem_port_arbiter_if.slave   bus,
    output arb_state_t          state_dbg
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_b_q, owner_b_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] hex_q, hex_d;

    logic              pick_b;
    logic              any_req;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_io;

    rr_pick2 u_rr (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .req_a    (bus.req_a),
        .req_b    (bus.req_b),
        .grant_en (state_q == ARB_IDLE),
        .pick_b   (pick_b)
    );

    // Winner's request fields, valid on the grant edge only.
    always_comb begin
        any_req   = bus.req_a || bus.req_b;
        sel_we    = pick_b ? bus.we_b    : bus.we_a;
        sel_addr  = pick_b ? bus.addr_b  : bus.addr_a;
        sel_wdata = pick_b ? bus.wdata_b : bus.wdata_a;
        sel_io    = (sel_addr == IO_ADDR);
    end

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: I/O accesses skip ACCESS and complete in one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:   if (any_req) state_d = sel_io ? ARB_DONE : ARB_ACCESS;
            ARB_ACCESS: if (cnt_q == '0) state_d = ARB_DONE;
            ARB_DONE:   state_d = ARB_IDLE;
            default:    state_d = ARB_IDLE;
        endcase
    end

    // Datapath next values: request latch, latency counter, read data, hex.
    always_comb begin
        cnt_d     = cnt_q;
        owner_b_d = owner_b_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        hex_d     = hex_q;
        case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    owner_b_d = pick_b;
                    we_d      = sel_we;
                    addr_d    = sel_addr;
                    wdata_d   = sel_wdata;
                    cnt_d     = CNT_W'(MEM_LAT - 1);
                    rdata_d   = '0;   // writes report zero read data
                    if (sel_io) begin
                        if (sel_we) hex_d   = sel_wdata;
                        else        rdata_d = DATA_W'(bus.sw);
                    end
                end
            end
            ARB_ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) rdata_d = bus.mem_rdata;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q     <= '0;
            owner_b_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            hex_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            owner_b_q <= owner_b_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            hex_q     <= hex_d;
        end
    end

    // Outputs: all derived from registered state, so reset clears them at once.
    always_comb begin
        bus.busy      = (state_q != ARB_IDLE);
        bus.gnt_a     = (state_q != ARB_IDLE) && !owner_b_q;
        bus.gnt_b     = (state_q != ARB_IDLE) &&  owner_b_q;
        bus.mem_ce    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.done_a    = 1'b0;
        bus.done_b    = 1'b0;
        bus.rdata_a   = '0;
        bus.rdata_b   = '0;
        bus.hex_out   = hex_q;
        state_dbg     = state_q;
        case (state_q)
            ARB_ACCESS: begin
                bus.mem_ce    = 1'b1;
                bus.mem_we    = we_q;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
            end
            ARB_DONE: begin
                if (owner_b_q) begin
                    bus.done_b  = 1'b1;
                    bus.rdata_b = rdata_q;
                end else begin
                    bus.done_a  = 1'b1;
                    bus.rdata_a = rdata_q;
                end
            end
            default: ;
        endcase
    end
endmodule
